// File: rtl/snake_frame_renderer.sv
// Consumer of the game FSM's serialized body stream. The body is captured into a
// double-buffered store, a snapshot is published per frame, and the grid is rendered.
module snake_frame_renderer #(
  parameter int SNAKE_LENGTH_MAX = 16,
  parameter int SNAKE_LENGTH_BIT = 4,
  parameter int CELL_SIZE        = 5,
  parameter int H_CELLS          = 124,
  parameter int V_CELLS          = 81,
  parameter int GAME_X0          = 10,
  parameter int GAME_Y0          = 65
) (
  input  logic                        clock_25,
  input  logic                        reset,
  input  logic                        en_snake_body,
  input  logic [6:0]                  snake_body_x,
  input  logic [6:0]                  snake_body_y,
  input  logic [6:0]                  snake_head_x,
  input  logic [6:0]                  snake_head_y,
  input  logic [6:0]                  fruit_x,
  input  logic [6:0]                  fruit_y,
  input  logic [SNAKE_LENGTH_BIT-1:0] snake_length,
  input  logic [9:0]                  pixel_x,
  input  logic [9:0]                  pixel_y,
  input  logic                        display_area,
  input  logic                        frame_start,
  output logic [3:0]                  red,
  output logic [3:0]                  green,
  output logic [3:0]                  blue,
  output logic                        frame_valid
);
  localparam int CNT_W = SNAKE_LENGTH_BIT + 1;
  localparam int SUB_W = $clog2(CELL_SIZE);
  localparam logic [13:0]      OFF_GRID = {7'h7F, 7'h7F};
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SNAKE_LENGTH_MAX);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CELL_SIZE - 1);
  localparam logic [9:0]       X_LO = 10'(GAME_X0);
  localparam logic [9:0]       X_HI = 10'(GAME_X0 + H_CELLS * CELL_SIZE);
  localparam logic [9:0]       Y_LO = 10'(GAME_Y0);
  localparam logic [9:0]       Y_HI = 10'(GAME_Y0 + V_CELLS * CELL_SIZE);

  logic [13:0] bank_q [2][SNAKE_LENGTH_MAX];
  logic [13:0] bank_d [2][SNAKE_LENGTH_MAX];
  logic                        en_d_q, en_d_d, sel_q, sel_d;
  logic                        capture_done_q, capture_done_d, frame_valid_q, frame_valid_d;
  logic [SNAKE_LENGTH_BIT-1:0] wr_idx_q, wr_idx_d, len_q, len_d;
  logic [CNT_W-1:0]            wr_cnt_q, wr_cnt_d;
  logic [6:0]                  head_x_q, head_x_d, head_y_q, head_y_d;
  logic [6:0]                  fruit_x_q, fruit_x_d, fruit_y_q, fruit_y_d;
  logic [9:0]                  prev_x_q, prev_x_d, prev_y_q, prev_y_d;
  logic [SUB_W-1:0]            sub_x_q, sub_x_d, sub_y_q, sub_y_d;
  logic [6:0]                  cell_x_q, cell_x_d, cell_y_q, cell_y_d;
  logic                        in_game_q, in_game_d, in_game2_q, in_game2_d;
  logic                        head_hit_q, head_hit_d, body_hit_q, body_hit_d;
  logic                        fruit_hit_q, fruit_hit_d;
  logic [11:0]                 rgb_q, rgb_d;

  // Stream capture into the shadow bank and per-frame snapshot publish.
  always_comb begin
    en_d_d         = en_snake_body;
    bank_d         = bank_q;
    wr_idx_d       = wr_idx_q;
    wr_cnt_d       = wr_cnt_q;
    capture_done_d = capture_done_q;
    sel_d          = sel_q;
    head_x_d       = head_x_q;
    head_y_d       = head_y_q;
    fruit_x_d      = fruit_x_q;
    fruit_y_d      = fruit_y_q;
    len_d          = len_q;
    frame_valid_d  = frame_valid_q;
    if (en_d_q) begin
      bank_d[~sel_q][wr_idx_q] = {snake_body_x, snake_body_y};
      wr_idx_d = wr_idx_q + SNAKE_LENGTH_BIT'(1);
      if (wr_cnt_q != CNT_FULL) begin
        wr_cnt_d = wr_cnt_q + CNT_W'(1);
      end else begin
        wr_cnt_d = wr_cnt_q;
      end
      if (wr_cnt_d == CNT_FULL) begin
        capture_done_d = 1'b1;
      end else begin
        capture_done_d = capture_done_q;
      end
    end else begin
      wr_idx_d = '0;
      wr_cnt_d = '0;
    end
    // Old capture_done decides, so a capture finishing this cycle waits a frame.
    if (frame_start && capture_done_q) begin
      sel_d          = ~sel_q;
      head_x_d       = snake_head_x;
      head_y_d       = snake_head_y;
      fruit_x_d      = fruit_x;
      fruit_y_d      = fruit_y;
      len_d          = snake_length;
      capture_done_d = 1'b0;
      wr_cnt_d       = '0;
      frame_valid_d  = 1'b1;
    end else begin
      sel_d = sel_q;
    end
  end

  // Stage 1: sub-cell and cell counters track the scan, reloading at the grid origin.
  always_comb begin
    prev_x_d  = pixel_x;
    prev_y_d  = pixel_y;
    sub_x_d   = sub_x_q;
    cell_x_d  = cell_x_q;
    sub_y_d   = sub_y_q;
    cell_y_d  = cell_y_q;
    in_game_d = display_area && (pixel_x >= X_LO) && (pixel_x < X_HI)
                && (pixel_y >= Y_LO) && (pixel_y < Y_HI);
    if (pixel_x == X_LO) begin
      sub_x_d  = '0;
      cell_x_d = 7'd0;
    end else if (pixel_x != prev_x_q) begin
      if (sub_x_q == SUB_LAST) begin
        sub_x_d  = '0;
        cell_x_d = cell_x_q + 7'd1;
      end else begin
        sub_x_d = sub_x_q + SUB_W'(1);
      end
    end else begin
      sub_x_d = sub_x_q;
    end
    if (pixel_y == Y_LO) begin
      sub_y_d  = '0;
      cell_y_d = 7'd0;
    end else if (pixel_y != prev_y_q) begin
      if (sub_y_q == SUB_LAST) begin
        sub_y_d  = '0;
        cell_y_d = cell_y_q + 7'd1;
      end else begin
        sub_y_d = sub_y_q + SUB_W'(1);
      end
    end else begin
      sub_y_d = sub_y_q;
    end
  end

  // Stage 2: parallel hit tests; index+1 < length avoids underflow at length 0.
  always_comb begin
    in_game2_d  = in_game_q;
    head_hit_d  = (cell_x_q == head_x_q) && (cell_y_q == head_y_q);
    fruit_hit_d = (cell_x_q == fruit_x_q) && (cell_y_q == fruit_y_q);
    body_hit_d  = 1'b0;
    for (int i = 0; i < SNAKE_LENGTH_MAX; i++) begin
      body_hit_d = body_hit_d
                   | (((CNT_W'(i) + CNT_W'(1)) < {1'b0, len_q})
                      && (bank_q[sel_q][i] == {cell_x_q, cell_y_q}));
    end
  end

  // Stage 3: colour priority.
  always_comb begin
    if (!in_game2_q) begin
      rgb_d = 12'h000;
    end else if (head_hit_q) begin
      rgb_d = 12'hFF0;
    end else if (body_hit_q) begin
      rgb_d = 12'h0F0;
    end else if (fruit_hit_q) begin
      rgb_d = 12'hF00;
    end else begin
      rgb_d = 12'h030;
    end
  end

  // State registers.
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < SNAKE_LENGTH_MAX; i++) begin
          bank_q[b][i] <= OFF_GRID;
        end
      end
      en_d_q <= 1'b0;  sel_q <= 1'b0;  capture_done_q <= 1'b0;  frame_valid_q <= 1'b0;
      wr_idx_q <= '0;  wr_cnt_q <= '0;  len_q <= '0;
      head_x_q <= 7'h7F;  head_y_q <= 7'h7F;  fruit_x_q <= 7'h7F;  fruit_y_q <= 7'h7F;
      prev_x_q <= 10'd0;  prev_y_q <= 10'd0;
      sub_x_q <= '0;  sub_y_q <= '0;  cell_x_q <= 7'd0;  cell_y_q <= 7'd0;
      in_game_q <= 1'b0;  in_game2_q <= 1'b0;
      head_hit_q <= 1'b0;  body_hit_q <= 1'b0;  fruit_hit_q <= 1'b0;
      rgb_q <= 12'h000;
    end else begin
      bank_q <= bank_d;
      en_d_q <= en_d_d;  sel_q <= sel_d;  capture_done_q <= capture_done_d;
      frame_valid_q <= frame_valid_d;
      wr_idx_q <= wr_idx_d;  wr_cnt_q <= wr_cnt_d;  len_q <= len_d;
      head_x_q <= head_x_d;  head_y_q <= head_y_d;
      fruit_x_q <= fruit_x_d;  fruit_y_q <= fruit_y_d;
      prev_x_q <= prev_x_d;  prev_y_q <= prev_y_d;
      sub_x_q <= sub_x_d;  sub_y_q <= sub_y_d;  cell_x_q <= cell_x_d;  cell_y_q <= cell_y_d;
      in_game_q <= in_game_d;  in_game2_q <= in_game2_d;
      head_hit_q <= head_hit_d;  body_hit_q <= body_hit_d;  fruit_hit_q <= fruit_hit_d;
      rgb_q <= rgb_d;
    end
  end

  assign red         = rgb_q[11:8];
  assign green       = rgb_q[7:4];
  assign blue        = rgb_q[3:0];
  assign frame_valid = frame_valid_q;
endmodule

// File: tb/tb_snake_frame_renderer.sv
// Directed bench for snake_frame_renderer: capture, publish, cell mapping, colour priority.
`timescale 1ns/1ps
module tb_snake_frame_renderer;
  localparam int GX0 = 10;
  localparam int GY0 = 65;

  logic       clock_25, reset, en_snake_body, display_area, frame_start;
  logic [6:0] snake_body_x, snake_body_y, snake_head_x, snake_head_y, fruit_x, fruit_y;
  logic [3:0] snake_length;
  logic [9:0] pixel_x, pixel_y;
  logic [3:0] red, green, blue;
  logic       frame_valid;
  logic [13:0] seg [16];
  int checks = 0;
  int errors = 0;

  snake_frame_renderer dut (
    .clock_25(clock_25), .reset(reset), .en_snake_body(en_snake_body),
    .snake_body_x(snake_body_x), .snake_body_y(snake_body_y),
    .snake_head_x(snake_head_x), .snake_head_y(snake_head_y),
    .fruit_x(fruit_x), .fruit_y(fruit_y), .snake_length(snake_length),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .display_area(display_area),
    .frame_start(frame_start), .red(red), .green(green), .blue(blue),
    .frame_valid(frame_valid)
  );

  initial clock_25 = 1'b0;
  always #20 clock_25 = ~clock_25;

  task automatic step(input int n);
    repeat (n) @(posedge clock_25);
    #1;
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Walk the scan to (x,y) one pixel per cycle so the cell counters follow; (x,y) is left presented.
  task automatic goto_px(input int x, input int y);
    pixel_x = 10'd0;
    pixel_y = 10'(GY0);
    step(1);
    for (int yy = GY0 + 1; yy <= y; yy++) begin
      pixel_y = 10'(yy);
      step(1);
    end
    if (y < GY0) begin
      pixel_y = 10'(y);
      step(1);
    end
    pixel_x = 10'(GX0);
    step(1);
    for (int xx = GX0 + 1; xx < x; xx++) begin
      pixel_x = 10'(xx);
      step(1);
    end
    pixel_x = 10'(x);
  endtask

  task automatic clear_seg();
    for (int i = 0; i < 16; i++) seg[i] = 14'h3FFF;
  endtask

  // Producer: enable high n cycles, segment data one cycle behind the enable.
  task automatic burst(input int n, input bit fs_on_last);
    en_snake_body = 1'b1;
    step(1);
    for (int j = 0; j < n; j++) begin
      if (j == n - 1) en_snake_body = 1'b0;
      if (j == n - 1 && fs_on_last) frame_start = 1'b1;
      {snake_body_x, snake_body_y} = seg[j % 16];
      step(1);
      frame_start = 1'b0;
    end
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
  endtask

  initial begin
    reset = 1'b0;  en_snake_body = 1'b0;  display_area = 1'b1;  frame_start = 1'b0;
    snake_body_x = 7'd0;  snake_body_y = 7'd0;
    snake_head_x = 7'd0;  snake_head_y = 7'd0;  fruit_x = 7'd0;  fruit_y = 7'd0;
    snake_length = 4'd0;  pixel_x = 10'd0;  pixel_y = 10'd0;
    clear_seg();
    step(3);
    reset = 1'b1;
    step(2);

    // No snapshot yet: grid is background, then an asynchronous reset mid-line.
    goto_px(GX0 + 310, GY0 + 200);  step(3);
    check("nopub_in_game", {red, green, blue}, 12'h030);
    #5 reset = 1'b0;
    #1;
    check("reset_rgb", {red, green, blue}, 12'h000);
    check("reset_fv", {11'd0, frame_valid}, 12'h000);
    step(2);
    reset = 1'b1;
    goto_px(GX0 + 310, GY0 + 200);
    display_area = 1'b0;  step(3);
    check("display_off", {red, green, blue}, 12'h000);
    display_area = 1'b1;
    goto_px(GX0 - 1, GY0 + 200);  step(3);
    check("nopub_outside", {red, green, blue}, 12'h000);

    // Normal capture: head (62,40), body (61,40)(60,40)(59,40), length 4.
    clear_seg();
    seg[0] = {7'd61, 7'd40};  seg[1] = {7'd60, 7'd40};  seg[2] = {7'd59, 7'd40};
    snake_head_x = 7'd62;  snake_head_y = 7'd40;  fruit_x = 7'd100;  fruit_y = 7'd70;
    snake_length = 4'd4;
    burst(17, 1'b0);
    pulse_fs();
    check("pub_fv", {11'd0, frame_valid}, 12'h001);
    goto_px(GX0 + 310, GY0 + 200);  step(3);
    check("pub_head", {red, green, blue}, 12'hFF0);
    goto_px(GX0 + 305, GY0 + 200);  step(3);
    check("pub_body61", {red, green, blue}, 12'h0F0);
    goto_px(GX0 + 300, GY0 + 200);  step(3);
    check("pub_body60", {red, green, blue}, 12'h0F0);
    goto_px(GX0 + 290, GY0 + 200);  step(3);
    check("pub_bg58", {red, green, blue}, 12'h030);

    // Short burst of 9 then frame_start: nothing may change.
    clear_seg();
    for (int i = 0; i < 16; i++) seg[i] = {7'd62, 7'd40};
    snake_head_x = 7'd0;  snake_head_y = 7'd0;  snake_length = 4'd9;
    burst(9, 1'b0);
    pulse_fs();
    check("short_fv", {11'd0, frame_valid}, 12'h001);
    goto_px(GX0 + 305, GY0 + 200);  step(3);
    check("short_body", {red, green, blue}, 12'h0F0);
    goto_px(GX0 + 310, GY0 + 200);  step(3);
    check("short_head", {red, green, blue}, 12'hFF0);

    // Length 2 gates bank[1]; fruit shares the head cell.
    clear_seg();
    seg[0] = {7'd61, 7'd40};  seg[1] = {7'd59, 7'd40};
    snake_head_x = 7'd62;  snake_head_y = 7'd40;  fruit_x = 7'd62;  fruit_y = 7'd40;
    snake_length = 4'd2;
    burst(16, 1'b0);
    pulse_fs();
    goto_px(GX0 + 295, GY0 + 200);  step(3);
    check("gate_bank1", {red, green, blue}, 12'h030);
    goto_px(GX0 + 305, GY0 + 200);  step(3);
    check("gate_bank0", {red, green, blue}, 12'h0F0);
    goto_px(GX0 + 310, GY0 + 200);  step(3);
    check("prio_head_fruit", {red, green, blue}, 12'hFF0);

    // Capture completes on the frame_start cycle: swap waits for the next one.
    clear_seg();
    seg[0] = {7'd0, 7'd0};
    fruit_x = 7'd0;  fruit_y = 7'd0;  snake_length = 4'd1;
    burst(16, 1'b1);
    check("defer_fv", {11'd0, frame_valid}, 12'h001);
    goto_px(GX0, GY0);  step(3);
    check("defer_old_snapshot", {red, green, blue}, 12'h030);
    pulse_fs();
    goto_px(GX0 - 1, GY0);  step(3);
    pixel_x = 10'(GX0);  step(2);
    check("lat_n_plus_2", {red, green, blue}, 12'h000);
    step(1);
    check("fruit_len1", {red, green, blue}, 12'hF00);

    // Grid boundary: cell (123,80) is the last in-game cell.
    clear_seg();
    snake_head_x = 7'd123;  snake_head_y = 7'd80;  snake_length = 4'd1;
    burst(16, 1'b0);
    pulse_fs();
    goto_px(GX0 + 619, GY0 + 404);  step(3);
    check("edge_cell_123_80", {red, green, blue}, 12'hFF0);
    pixel_x = 10'(GX0 + 620);  step(3);
    check("edge_x_out", {red, green, blue}, 12'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
